// File: rtl/cpu_trace_buffer.sv
// Circular trace capture of CU/datapath activity with programmable trigger and post-trigger window.
// Optional build macro CPU_TRACE_TS_EN prepends a free-running cycle timestamp to every entry.
module cpu_trace_buffer #(
    parameter int PC_W   = 8,
    parameter int OP_W   = 3,
    parameter int RA_W   = 2,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int TS_W   = 16,
`ifdef CPU_TRACE_TS_EN
    localparam int TS_EN = 1,
`else
    localparam int TS_EN = 0,
`endif
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1,
    localparam int ENTRY_W = TS_EN * TS_W + PC_W + OP_W + RA_W + DATA_W + 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [PC_W-1:0]    pc,
    input  logic [OP_W-1:0]    opcode,
    input  logic               we,
    input  logic [RA_W-1:0]    wa,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               z,
    input  logic               c,
    input  logic               arm,
    input  logic               abort,
    input  logic [1:0]         trig_mode,
    input  logic [OP_W-1:0]    trig_opcode,
    input  logic [RA_W-1:0]    trig_wa,
    input  logic [CW-1:0]      post_len,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_idx,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               rd_err,
    output logic [1:0]         state,
    output logic [CW-1:0]      count,
    output logic [AW-1:0]      trig_pos,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      trig_ptr;
    logic [CW-1:0]      post_cnt;
    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic               wr, restart, load_trig, dec, trig_hit;
    logic [AW-1:0]      oldest, phys;
    logic               rd_ok;

`ifdef CPU_TRACE_TS_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts <= '0;
        else        ts <= ts + TS_W'(1);
    end

    assign entry = {ts, pc, opcode, we, wa, wdata, z, c};
`else
    assign entry = {pc, opcode, we, wa, wdata, z, c};
`endif

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode)
            2'd0:    trig_hit = 1'b1;
            2'd1:    trig_hit = (opcode == trig_opcode);
            2'd2:    trig_hit = we && (wa == trig_wa);
            default: trig_hit = 1'b0;
        endcase
    end

    // abort beats arm; arm in any state restarts capture without storing that cycle's sample
    always_comb begin
        state_d   = state_q;
        wr        = 1'b0;
        restart   = 1'b0;
        load_trig = 1'b0;
        dec       = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else if (arm) begin
            state_d = ARMED;
            restart = 1'b1;
        end else begin
            case (state_q)
                ARMED: if (sample_valid) begin
                    wr = 1'b1;
                    if (trig_hit) begin
                        load_trig = 1'b1;
                        state_d   = (post_len == '0) ? DONE : POST;
                    end
                end
                POST: if (sample_valid) begin
                    wr  = 1'b1;
                    dec = 1'b1;
                    if (post_cnt == CW'(1)) state_d = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= entry;
    end

    // Once the ring has wrapped, the slot about to be overwritten is the oldest entry
    assign oldest = (count == FULL) ? wr_ptr : '0;
    assign phys   = oldest + rd_idx;
    assign rd_ok  = ((state_q == IDLE) || (state_q == DONE)) && ({1'b0, rd_idx} < count);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            count    <= '0;
            trig_ptr <= '0;
            post_cnt <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            if (restart) begin
                wr_ptr <= '0;
                count  <= '0;
            end else if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (count != FULL) count <= count + CW'(1);
            end

            if (load_trig) begin
                trig_ptr <= wr_ptr;
                post_cnt <= post_len;
            end else if (dec) begin
                post_cnt <= post_cnt - CW'(1);
            end

            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            if (rd_en) begin
                if (rd_ok) begin
                    rd_data  <= mem[phys];
                    rd_valid <= 1'b1;
                end else begin
                    rd_err <= 1'b1;
                end
            end
        end
    end

    assign trig_pos = trig_ptr - oldest;
    assign state    = state_q;
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: table-driven readouts scored through a response queue,
// plus hand-written sequences for restart, abort and reset corner cases.
module tb_cpu_trace_buffer;

    localparam int PC_W = 8, OP_W = 3, RA_W = 2, DATA_W = 8, DEPTH = 32, TS_W = 16;
    localparam int AW = 5, CW = 6;
`ifdef CPU_TRACE_TS_EN
    localparam int TS_EN = 1;
`else
    localparam int TS_EN = 0;
`endif
    localparam int BASE_W  = PC_W + OP_W + RA_W + DATA_W + 3;
    localparam int ENTRY_W = TS_EN * TS_W + BASE_W;

    logic clk, reset, sample_valid, we, z, c, arm, abort, rd_en;
    logic [PC_W-1:0]    pc;
    logic [OP_W-1:0]    opcode, trig_opcode;
    logic [RA_W-1:0]    wa, trig_wa;
    logic [DATA_W-1:0]  wdata;
    logic [1:0]         trig_mode;
    logic [CW-1:0]      post_len;
    logic [AW-1:0]      rd_idx;
    logic [ENTRY_W-1:0] rd_data;
    logic               rd_valid, rd_err, done;
    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [AW-1:0]      trig_pos;

    cpu_trace_buffer dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .pc(pc), .opcode(opcode),
        .we(we), .wa(wa), .wdata(wdata), .z(z), .c(c), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .trig_opcode(trig_opcode), .trig_wa(trig_wa),
        .post_len(post_len), .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_err(rd_err), .state(state), .count(count),
        .trig_pos(trig_pos), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             ok;
        logic [BASE_W-1:0] data;
    } exp_t;

    typedef struct {
        int   idx;
        logic ok;
        int   pc;
    } rd_vec_t;

    exp_t sbq[$];
    int n_checks = 0;
    int n_pass   = 0;
    int op_pc    = -1;
    int wa_pc    = -1;
    logic [BASE_W-1:0]  last_good = '0;
    logic [ENTRY_W-1:0] last_rd   = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    // Snoop fields are a fixed function of pc; only the chosen trigger pc carries the match
    function automatic logic [BASE_W-1:0] mk_entry(input int p);
        logic [7:0] pv, d;
        logic [2:0] op;
        logic       w;
        logic [1:0] a;
        pv = p[7:0];
        op = (pv[2:0] == 3'd5) ? 3'd4 : pv[2:0];
        if (p == op_pc) op = 3'd5;
        w = pv[0];
        a = pv[1] ? 2'd3 : 2'd1;
        if (p == wa_pc) begin
            w = 1'b1;
            a = 2'd2;
        end
        d = pv * 8'd3 + 8'd1;
        return {pv, op, w, a, d, (d == 8'd0), pv[3]};
    endfunction

    task automatic drive_sample(input int p);
        {pc, opcode, we, wa, wdata, z, c} = mk_entry(p);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic do_read(input int idx, input logic ok, input int p);
        exp_t e;
        e.ok   = ok;
        e.data = ok ? mk_entry(p) : last_good;
        if (ok) last_good = e.data;
        sbq.push_back(e);
        rd_en  = 1'b1;
        rd_idx = idx[AW-1:0];
        @(negedge clk);
        rd_en = 1'b0;
        #1;
        if (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL rd_timeout: got no response for idx %0d, required one", idx);
            sbq.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid || rd_err) begin
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got valid=%0b err=%0b, required none", rd_valid, rd_err);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rd_valid", rd_valid, e.ok);
                check("rd_err", rd_err, !e.ok);
                check("rd_data", rd_data[BASE_W-1:0], e.data);
                last_rd = rd_data;
            end
        end
    end

    task automatic check_status(input string nm, input int st, input int cnt);
        check({nm, "_state"}, state, st);
        check({nm, "_count"}, count, cnt);
        check({nm, "_done"}, done, (st == 3));
    endtask

    rd_vec_t t1[5];
    rd_vec_t t3[7];

    initial begin
        t1[0] = '{0, 1'b1, 0};
        t1[1] = '{1, 1'b1, 1};
        t1[2] = '{2, 1'b1, 2};
        t1[3] = '{3, 1'b1, 3};
        t1[4] = '{4, 1'b0, 0};
        t3[0] = '{0, 1'b1, 24};
        t3[1] = '{31, 1'b1, 55};
        t3[2] = '{21, 1'b1, 45};
        t3[3] = '{5, 1'b1, 29};
        t3[4] = '{8, 1'b1, 32};
        t3[5] = '{7, 1'b1, 31};
        t3[6] = '{30, 1'b1, 54};

        reset = 1'b0; sample_valid = 0; arm = 0; abort = 0; rd_en = 0; rd_idx = '0;
        {pc, opcode, we, wa, wdata, z, c} = '0;
        trig_mode = 2'd0; trig_opcode = '0; trig_wa = '0; post_len = '0;
        repeat (3) @(negedge clk);
        check_status("reset", 0, 0);
        check("reset_trig_pos", trig_pos, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_err", rd_err, 0);
        check("reset_rd_data", rd_data, 0);
        reset = 1'b1;
        @(negedge clk);

        // Immediate trigger, short window
        trig_mode = 2'd0; post_len = 6'd3;
        pulse_arm();
        check_status("m0_armed", 1, 0);
        drive_sample(0);
        check_status("m0_post", 2, 1);
        for (int p = 1; p < 4; p++) drive_sample(p);
        check_status("m0_done", 3, 4);
        check("m0_trig_pos", trig_pos, 0);
        drive_sample(4);
        check_status("m0_frozen", 3, 4);
        foreach (t1[i]) do_read(t1[i].idx, t1[i].ok, t1[i].pc);

        // Reads are refused while capturing, allowed after abort
        trig_mode = 2'd3;
        pulse_arm();
        for (int p = 0; p < 6; p++) drive_sample(p);
        check_status("never_armed", 1, 6);
        do_read(5, 1'b0, 0);
        pulse_abort();
        check_status("abort_idle", 0, 6);
        do_read(5, 1'b1, 5);

        // Index past a short capture is refused
        trig_mode = 2'd0; post_len = 6'd2;
        pulse_arm();
        for (int p = 0; p < 3; p++) drive_sample(p);
        check_status("cnt3_done", 3, 3);
        do_read(5, 1'b0, 0);
        do_read(2, 1'b1, 2);

        // Opcode trigger before the ring wraps
        trig_mode = 2'd1; trig_opcode = 3'b101; post_len = 6'd5; op_pc = 20;
        pulse_arm();
        for (int p = 0; p < 40; p++) drive_sample(p);
        check_status("m1_done", 3, 26);
        check("m1_trig_pos", trig_pos, 20);
        do_read(0, 1'b1, 0);
        do_read(20, 1'b1, 20);
        do_read(25, 1'b1, 25);
        do_read(26, 1'b0, 0);
        op_pc = -1;

        // Write-address trigger after the ring has wrapped
        trig_mode = 2'd2; trig_wa = 2'd2; post_len = 6'd10; wa_pc = 45;
        pulse_arm();
        for (int p = 0; p < 60; p++) drive_sample(p);
        check_status("m2_done", 3, 32);
        check("m2_trig_pos", trig_pos, 21);
        foreach (t3[i]) do_read(t3[i].idx, t3[i].ok, t3[i].pc);
        wa_pc = -1;

        // Zero-length window finishes on the trigger sample itself
        trig_mode = 2'd0; post_len = 6'd0;
        pulse_arm();
        drive_sample(7);
        check_status("pl0_done", 3, 1);
        do_read(0, 1'b1, 7);

        // arm in POST restarts; arm+abort together in POST goes idle
        post_len = 6'd10;
        pulse_arm();
        for (int p = 0; p < 3; p++) drive_sample(p);
        check_status("restart_post", 2, 3);
        pulse_arm();
        check_status("restart_armed", 1, 0);
        drive_sample(0);
        drive_sample(1);
        arm = 1'b1; abort = 1'b1;
        @(negedge clk);
        arm = 1'b0; abort = 1'b0;
        check_status("arm_abort", 0, 2);

        // Asynchronous reset in the middle of the post window
        pulse_arm();
        drive_sample(0);
        drive_sample(1);
        check_status("pre_reset", 2, 2);
        reset = 1'b0;
        #1;
        check_status("mid_reset", 0, 0);
        last_good = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_read(0, 1'b0, 0);

`ifdef CPU_TRACE_TS_EN
        begin
            logic [TS_W-1:0] t0, t1v;
            trig_mode = 2'd3;
            pulse_arm();
            drive_sample(0);
            @(negedge clk);
            drive_sample(1);
            pulse_abort();
            do_read(0, 1'b1, 0);
            t0 = last_rd[ENTRY_W-1 -: TS_W];
            do_read(1, 1'b1, 1);
            t1v = last_rd[ENTRY_W-1 -: TS_W];
            check("ts_delta", t1v - t0, 2);
        end
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
